// File: rtl/br_sfifo_param_if.sv
// Handshake bundle for br_sfifo_param: write/read requests, data and all status flags.
interface br_sfifo_param_if #(
  parameter int WIDTH = 32,
  parameter int PTR   = 4
);
  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             wrfull;
  logic             wralmost_full;
  logic             rdreq;
  logic [WIDTH-1:0] q;
  logic             rdempty;
  logic             rdalmost_empty;
  logic [PTR:0]     usedw;
  logic             ovf_err;
  logic             udf_err;

  modport master (
    output wrreq, data, rdreq,
    input  wrfull, wralmost_full, q, rdempty, rdalmost_empty, usedw, ovf_err, udf_err
  );

  modport slave (
    input  wrreq, data, rdreq,
    output wrfull, wralmost_full, q, rdempty, rdalmost_empty, usedw, ovf_err, udf_err
  );
endinterface

// File: rtl/br_sfifo_param.sv
// Parametrised single-clock FIFO with registered flags and sticky error bits.
// Define BR_SFIFO_FWFT_EN for first-word-fall-through reads; default is registered q.
module br_sfifo_param #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int PTR       = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input logic              clk,
  input logic              aclr,
  input logic              sclr,
  br_sfifo_param_if.slave  bus
);

  localparam logic [PTR:0]   DEPTH_C = DEPTH[PTR:0];
  localparam logic [PTR:0]   AF_C    = AF_THRESH[PTR:0];
  localparam logic [PTR:0]   AE_C    = AE_THRESH[PTR:0];
  localparam logic [PTR:0]   CNT_ONE = {{PTR{1'b0}}, 1'b1};
  localparam logic [PTR-1:0] PTR_ONE = {{(PTR-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR-1:0]   wr_ptr;
  logic [PTR-1:0]   rd_ptr;
  logic [PTR:0]     cnt;
  logic [PTR:0]     cnt_nxt;
  logic             full_r;
  logic             empty_r;
  logic             af_r;
  logic             ae_r;
  logic             ovf_r;
  logic             udf_r;
  logic             wr_acc;
  logic             rd_acc;

  // A full FIFO still takes a write when the same edge pops a word.
  assign rd_acc = bus.rdreq & ~empty_r;
  assign wr_acc = bus.wrreq & (~full_r | rd_acc);

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !rd_acc)
      cnt_nxt = cnt + CNT_ONE;
    else if (rd_acc && !wr_acc)
      cnt_nxt = cnt - CNT_ONE;
  end

  // Flags are computed from the post-edge count so they never lag usedw.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else if (sclr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      cnt     <= cnt_nxt;
      full_r  <= (cnt_nxt == DEPTH_C);
      empty_r <= (cnt_nxt == '0);
      af_r    <= (cnt_nxt >= AF_C);
      ae_r    <= (cnt_nxt <= AE_C);
      if (bus.wrreq && full_r && !rd_acc)
        ovf_r <= 1'b1;
      if (bus.rdreq && empty_r)
        udf_r <= 1'b1;
    end
  end

  // Storage is never cleared; pointers and count alone define the contents.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= bus.data;
  end

`ifdef BR_SFIFO_FWFT_EN
  // Head word is shown whenever data is present; forced to zero while empty.
  assign bus.q = empty_r ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] q_r;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      q_r <= '0;
    else if (sclr)
      q_r <= '0;
    else if (rd_acc)
      q_r <= mem[rd_ptr];
  end

  assign bus.q = q_r;
`endif

  assign bus.usedw          = cnt;
  assign bus.wrfull         = full_r;
  assign bus.rdempty        = empty_r;
  assign bus.wralmost_full  = af_r;
  assign bus.rdalmost_empty = ae_r;
  assign bus.ovf_err        = ovf_r;
  assign bus.udf_err        = udf_r;

endmodule

// File: doc/br_sfifo_param.md
Name: br_sfifo_param

Overview:
- Parametrised single-clock synchronous FIFO in native RTL (register-array storage, no vendor IP). Successor to the fixed 4x32 buffer.
- Adds generic width/depth, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous clear, and optional first-word-fall-through (FWFT) read mode.
- Used as the elastic buffer between LMAC core pipeline stages in the same clock domain.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of 2, >=2.
- PTR, 4, log2(DEPTH); pointer width.
- AF_THRESH, 12, wralmost_full asserts when usedw >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, rdalmost_empty asserts when usedw <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  single clock for read and write.
- aclr  in  1  asynchronous reset, active-high.
- sclr  in  1  synchronous clear; same effect as aclr, applied at the clk edge.
- wrreq  in  1  write request.
- data  in  WIDTH  write data.
- wrfull  out  1  FIFO full (usedw == DEPTH).
- wralmost_full  out  1  usedw >= AF_THRESH.
- rdreq  in  1  read request.
- q  out  WIDTH  read data.
- rdempty  out  1  FIFO empty (usedw == 0).
- rdalmost_empty  out  1  usedw <= AE_THRESH.
- usedw  out  PTR+1  occupied entries, 0..DEPTH.
- ovf_err  out  1  sticky: a write was attempted while full and not accepted.
- udf_err  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (aclr high, async) or sclr (sync): wr_ptr=0, rd_ptr=0, usedw=0, rdempty=1, wrfull=0, rdalmost_empty=1, wralmost_full=0 (AF_THRESH>=1), q=0, ovf_err=0, udf_err=0. Storage array is not reset. sclr has priority over wrreq/rdreq in the same cycle.
- Accept rules per edge: wr_acc = wrreq & (~wrfull | rd_acc); rd_acc = rdreq & ~rdempty.
- Full plus simultaneous rdreq&wrreq: both accepted, usedw stays DEPTH.
- Empty plus simultaneous rdreq&wrreq: write accepted, read rejected, udf_err set, usedw becomes 1.
- Pointers are PTR bits wide and wrap DEPTH-1 -> 0 naturally. usedw is a separate PTR+1-bit counter: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- All flags are registered and updated on the same edge as usedw, so they always match the post-edge count. No combinational path from wrreq/rdreq to any flag.
- Write-to-read latency: a word written at edge N clears rdempty after edge N; it is readable from cycle N+1.
- Standard mode: q loads mem[rd_ptr] at the edge where rd_acc=1 and is valid from the next cycle. q holds its value when there is no accepted read.
- ovf_err is set when wrreq & wrfull & ~rd_acc. udf_err is set when rdreq & rdempty. Both are cleared only by aclr or sclr.
- aclr asserted mid-stream discards all contents immediately. Outputs go to reset values asynchronously.

Optional Feature:
- Macro BR_SFIFO_FWFT_EN.
- Defined: q = mem[rd_ptr] combinationally from the register array. The head word is presented whenever rdempty=0, and rdreq acts as an acknowledge that pops it at the edge. q is don't-care while rdempty=1. After the first write into an empty FIFO, q is valid in the same cycle rdempty falls.
- Undefined: standard mode above, with one-cycle registered read latency.
- Flags, usedw and error behaviour are identical in both modes.

Test Plan:
- DEPTH=8, AF=6, AE=1. Write 0x11..0x88 in 8 consecutive cycles -> usedw 1..8. wralmost_full rises after the 6th write, wrfull after the 8th. rdalmost_empty falls after the 2nd write.
- Full FIFO, 9th wrreq with data=0xDEAD and no rdreq -> ovf_err=1, usedw stays 8. Subsequent reads return 0x11..0x88; 0xDEAD never appears.
- Full FIFO, simultaneous wrreq(0x99) and rdreq -> usedw stays 8, wrfull stays 1, ovf_err stays 0. Read-out order ends with 0x99.
- Empty FIFO, rdreq plus wrreq(0x42) in the same cycle -> udf_err=1, usedw=1. Next read returns 0x42 (standard mode: valid the cycle after rdreq; FWFT: q=0x42 as soon as rdempty=0).
- 20 writes and 20 reads interleaved across pointer wrap at DEPTH=8 -> data order preserved, usedw never exceeds 8, final usedw=0, rdempty=1.
- Load 5 words, pulse aclr mid-cycle -> usedw=0, rdempty=1, q=0 immediately. Repeat with sclr: same values after the next edge, and a write in the sclr cycle is dropped.
